ser2par16: RTL and testbench



---
 rtl/ser2par16_if.sv | 24 ++
 rtl/ser2par16.sv | 113 +++++++++++
 tb/tb_ser2par16.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ser2par16_if.sv
// Serial-in / parallel-out bus for ser2par16: frame control and serial stream in,
// assembled word plus capture/busy/error status out.
interface ser2par16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             abort;
    logic             sdata_vld;
    logic             sdata;
    logic [WIDTH-1:0] par_D;
    logic             cap_EN;
    logic             busy;
    logic             err;

    modport master (
        output start, abort, sdata_vld, sdata,
        input  par_D, cap_EN, busy, err
    );

    modport slave (
        input  start, abort, sdata_vld, sdata,
        output par_D, cap_EN, busy, err
    );
endinterface

// File: rtl/ser2par16.sv
// Assembles a WIDTH-bit word from a valid-qualified serial stream and strobes cap_EN
// for one cycle so a downstream enabled register captures each completed word.
module ser2par16 #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic        clk,
    input logic        CLRN,
    ser2par16_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count;
    logic             cap_en;
    logic             busy_r;
    logic             err_r;
    logic             last_bit;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sreg[WIDTH-2:0], bus.sdata};
        end else begin : g_lsb
            assign shifted = {bus.sdata, sreg[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (count == CW'(WIDTH - 1));

    // cap_EN and busy are registered alongside the state they decode, so every branch
    // that picks a next state also sets the matching status bit.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state  <= IDLE;
            sreg   <= '0;
            count  <= '0;
            cap_en <= 1'b0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            cap_en <= 1'b0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.abort) begin
                        count <= '0;
                    end else if (bus.start) begin
                        state  <= SHIFT;
                        sreg   <= '0;
                        count  <= '0;
                        busy_r <= 1'b1;
                    end else if (bus.sdata_vld) begin
                        err_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        if (bus.start) begin
                            err_r <= 1'b1;
                        end
                        if (bus.sdata_vld) begin
                            sreg  <= shifted;
                            count <= count + CW'(1);
                            if (last_bit) begin
                                state  <= DONE;
                                cap_en <= 1'b1;
                            end else begin
                                busy_r <= 1'b1;
                            end
                        end else begin
                            busy_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The completed word is still on par_D during this cycle; a restart
                    // clears sreg only at its end, after downstream has captured it.
                    if (bus.abort) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (bus.start) begin
                        state  <= SHIFT;
                        sreg   <= '0;
                        count  <= '0;
                        busy_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                        if (bus.sdata_vld) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign bus.par_D  = sreg;
    assign bus.cap_EN = cap_en;
    assign bus.busy   = busy_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_ser2par16.sv
// Directed bench for ser2par16: an LSB-first and an MSB-first instance share one
// stimulus stream, each feeding a model of the downstream enabled register.
module tb_ser2par16;
    logic clk = 1'b0;
    logic CLRN;
    logic startIn;
    logic abortIn;
    logic vldIn;
    logic sdataIn;

    int checks = 0;
    int bad    = 0;
    int busyCnt;
    int capCnt;
    int errCnt;

    logic [15:0] dsRegA = '0;
    logic [15:0] dsRegB = '0;
    logic [15:0] capLog[$];

    always #5 clk = ~clk;

    ser2par16_if #(.WIDTH(16)) busA ();
    ser2par16_if #(.WIDTH(16)) busB ();

    assign busA.start     = startIn;
    assign busA.abort     = abortIn;
    assign busA.sdata_vld = vldIn;
    assign busA.sdata     = sdataIn;
    assign busB.start     = startIn;
    assign busB.abort     = abortIn;
    assign busB.sdata_vld = vldIn;
    assign busB.sdata     = sdataIn;

    ser2par16 #(.WIDTH(16), .MSB_FIRST(1'b0)) dutA (
        .clk  (clk),
        .CLRN (CLRN),
        .bus  (busA)
    );

    ser2par16 #(.WIDTH(16), .MSB_FIRST(1'b1)) dutB (
        .clk  (clk),
        .CLRN (CLRN),
        .bus  (busB)
    );

    // Downstream 16-bit enabled registers, plus a log of every word instance A hands over.
    always @(posedge clk) begin
        if (busA.cap_EN) begin
            dsRegA <= busA.par_D;
            capLog.push_back(busA.par_D);
        end
        if (busB.cap_EN) begin
            dsRegB <= busB.par_D;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busA.busy)   busyCnt++;
        if (busA.cap_EN) capCnt++;
        if (busA.err)    errCnt++;
    endtask

    task automatic clearCounts();
        busyCnt = 0;
        capCnt  = 0;
        errCnt  = 0;
    endtask

    // Start cycle, then nBits valid bits; three idle cycles follow bit number gapA and gapB.
    task automatic applyStimulus(input logic [15:0] word, input int nBits, input int gapA,
                                 input int gapB, input bit msbOrder);
        startIn = 1'b1;
        tick();
        startIn = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            vldIn   = 1'b1;
            sdataIn = msbOrder ? word[15-i] : word[i];
            tick();
            vldIn   = 1'b0;
            sdataIn = 1'b0;
            if (i + 1 == gapA || i + 1 == gapB) begin
                repeat (3) tick();
            end
        end
    endtask

    initial begin
        startIn = 1'b0;
        abortIn = 1'b0;
        vldIn   = 1'b0;
        sdataIn = 1'b0;
        clearCounts();

        CLRN = 1'b1;
        #2 CLRN = 1'b0;
        #1;
        checkOutput("rst par_D",  32'(busA.par_D),  32'h0);
        checkOutput("rst cap_EN", 32'(busA.cap_EN), 32'h0);
        checkOutput("rst busy",   32'(busA.busy),   32'h0);
        checkOutput("rst err",    32'(busA.err),    32'h0);
        repeat (2) tick();
        CLRN = 1'b1;
        tick();

        clearCounts();
        applyStimulus(16'hA5C3, 16, 0, 0, 1'b0);
        checkOutput("f1 cap_EN", 32'(busA.cap_EN), 32'h1);
        checkOutput("f1 par_D",  32'(busA.par_D),  32'hA5C3);
        checkOutput("f1 busyN",  32'(busyCnt),     32'd16);
        checkOutput("f1 msb par_D", 32'(busB.par_D), 32'hC3A5);
        tick();
        checkOutput("f1 ds",     32'(dsRegA),      32'hA5C3);
        checkOutput("f1 capN",   32'(capCnt),      32'd1);
        checkOutput("f1 errN",   32'(errCnt),      32'd0);

        clearCounts();
        applyStimulus(16'hA5C3, 16, 4, 11, 1'b0);
        checkOutput("gap par_D", 32'(busA.par_D),  32'hA5C3);
        checkOutput("gap busyN", 32'(busyCnt),     32'd22);
        tick();
        checkOutput("gap capN",  32'(capCnt),      32'd1);
        checkOutput("gap ds",    32'(dsRegA),      32'hA5C3);

        clearCounts();
        applyStimulus(16'hA5C3, 7, 0, 0, 1'b0);
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        checkOutput("abort busy",  32'(busA.busy),  32'h0);
        checkOutput("abort par_D", 32'(busA.par_D), 32'h8600);
        repeat (3) tick();
        checkOutput("abort capN",  32'(capCnt),     32'd0);
        clearCounts();
        applyStimulus(16'h0001, 16, 0, 0, 1'b0);
        checkOutput("post-abort par_D", 32'(busA.par_D), 32'h0001);
        tick();
        checkOutput("post-abort ds",    32'(dsRegA),     32'h0001);
        checkOutput("post-abort capN",  32'(capCnt),     32'd1);

        startIn = 1'b1;
        tick();
        startIn = 1'b0;
        checkOutput("restart busy", 32'(busA.busy), 32'h1);
        startIn = 1'b1;
        tick();
        startIn = 1'b0;
        checkOutput("start in shift err", 32'(busA.err), 32'h1);
        tick();
        checkOutput("err one cycle", 32'(busA.err), 32'h0);
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        startIn = 1'b1;
        vldIn   = 1'b1;
        tick();
        startIn = 1'b0;
        vldIn   = 1'b0;
        checkOutput("start+vld no err", 32'(busA.err), 32'h0);
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;

        applyStimulus(16'hA5C3, 9, 0, 0, 1'b0);
        checkOutput("mid busy", 32'(busA.busy), 32'h1);
        #2 CLRN = 1'b0;
        #1;
        checkOutput("async par_D",  32'(busA.par_D),  32'h0);
        checkOutput("async busy",   32'(busA.busy),   32'h0);
        checkOutput("async cap_EN", 32'(busA.cap_EN), 32'h0);
        #1 CLRN = 1'b1;
        vldIn = 1'b1;
        tick();
        vldIn = 1'b0;
        checkOutput("stray vld err", 32'(busA.err), 32'h1);
        tick();
        checkOutput("stray err drop", 32'(busA.err), 32'h0);

        applyStimulus(16'h8001, 16, 0, 0, 1'b1);
        checkOutput("msb cap_EN", 32'(busB.cap_EN), 32'h1);
        checkOutput("msb par_D",  32'(busB.par_D),  32'h8001);
        tick();
        checkOutput("msb ds",     32'(dsRegB),      32'h8001);

        clearCounts();
        capLog.delete();
        applyStimulus(16'h1234, 16, 0, 0, 1'b0);
        checkOutput("b2b w1 par_D", 32'(busA.par_D), 32'h1234);
        applyStimulus(16'hFFFF, 16, 0, 0, 1'b0);
        checkOutput("b2b w2 par_D", 32'(busA.par_D), 32'hFFFF);
        tick();
        checkOutput("b2b capN", 32'(capCnt),        32'd2);
        checkOutput("b2b logN", 32'(capLog.size()), 32'd2);
        if (capLog.size() == 2) begin
            checkOutput("b2b ds0", 32'(capLog[0]), 32'h1234);
            checkOutput("b2b ds1", 32'(capLog[1]), 32'hFFFF);
        end
        checkOutput("b2b ds",   32'(dsRegA),        32'hFFFF);
        checkOutput("b2b errN", 32'(errCnt),        32'd0);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end
endmodule
